// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto one single-outstanding memory port.
// Ports: clk, rst; imem_* fetch side; dmem_* data side; mem_* shared port;
//        busy (activity indicator); proto_err (sticky request-while-busy flag).
module mem_port_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   input  logic        imem_flush,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        busy,
   output logic        proto_err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t      state;
   logic        ibuf_v;
   logic [31:0] ibuf_addr;
   logic [3:0]  ibuf_rmask;
   logic        dbuf_v;
   logic [31:0] dbuf_addr;
   logic [3:0]  dbuf_rmask;
   logic [3:0]  dbuf_wmask;
   logic [31:0] dbuf_wdata;
   logic        drop;
   logic        last_d;

   logic        i_req;
   logic        d_req;
   logic        i_busy;
   logic        d_busy;
   logic        i_acc;
   logic        d_acc;
   logic        i_err;
   logic        d_err;
   logic        i_pend;
   logic        d_pend;
   logic        done;
   logic        can_issue;
   logic        grant_i;
   logic        grant_d;
   logic [31:0] i_addr;
   logic [3:0]  i_rm;
   logic [31:0] d_addr;
   logic [3:0]  d_rm;
   logic [3:0]  d_wm;
   logic [31:0] d_wdata;

   assign i_req = |imem_rmask;
   assign d_req = (|dmem_rmask) | (|dmem_wmask);
   assign done  = (state != IDLE) && mem_resp;

   // The completion cycle no longer counts as in flight, so a requester
   // may follow its own response back-to-back.
   assign i_busy = (state == BUSY_I) && !mem_resp;
   assign d_busy = (state == BUSY_D) && !mem_resp;

   assign i_acc = i_req && !imem_flush && !ibuf_v && !i_busy;
   assign i_err = i_req && !imem_flush && (ibuf_v || i_busy);
   assign d_acc = d_req && !dbuf_v && !d_busy;
   assign d_err = d_req && (dbuf_v || d_busy);

   // A request accepted this cycle is pending at this edge (bypass).
   assign i_pend = (ibuf_v && !imem_flush) || i_acc;
   assign d_pend = dbuf_v || d_acc;

   assign can_issue = (state == IDLE) || done;
   assign grant_d   = can_issue && d_pend &&
                      (!i_pend || !RR_EN || !last_d);
   assign grant_i   = can_issue && i_pend && !grant_d;

   assign i_addr  = ibuf_v ? ibuf_addr  : imem_addr;
   assign i_rm    = ibuf_v ? ibuf_rmask : imem_rmask;
   assign d_addr  = dbuf_v ? dbuf_addr  : dmem_addr;
   assign d_wm    = dbuf_v ? dbuf_wmask : dmem_wmask;
   assign d_wdata = dbuf_v ? dbuf_wdata : dmem_wdata;
   // A combined read+write request is treated as a plain write.
   assign d_rm    = dbuf_v ? dbuf_rmask :
                    ((|dmem_wmask) ? 4'h0 : dmem_rmask);

   assign imem_resp  = !rst && (state == BUSY_I) && mem_resp &&
                       !drop && !imem_flush;
   assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
   assign dmem_resp  = !rst && (state == BUSY_D) && mem_resp;
   assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
   assign busy       = !rst && (ibuf_v || dbuf_v || (state != IDLE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ibuf_v     <= 1'b0;
         ibuf_addr  <= 32'h0;
         ibuf_rmask <= 4'h0;
         dbuf_v     <= 1'b0;
         dbuf_addr  <= 32'h0;
         dbuf_rmask <= 4'h0;
         dbuf_wmask <= 4'h0;
         dbuf_wdata <= 32'h0;
         drop       <= 1'b0;
         last_d     <= 1'b0;
         proto_err  <= 1'b0;
         mem_addr   <= 32'h0;
         mem_rmask  <= 4'h0;
         mem_wmask  <= 4'h0;
         mem_wdata  <= 32'h0;
      end else begin
         mem_rmask <= 4'h0;
         mem_wmask <= 4'h0;
         proto_err <= proto_err | i_err | d_err;

         if (imem_flush) begin
            ibuf_v <= 1'b0;
         end else if (grant_i) begin
            ibuf_v <= 1'b0;
         end else if (i_acc) begin
            ibuf_v     <= 1'b1;
            ibuf_addr  <= imem_addr;
            ibuf_rmask <= imem_rmask;
         end

         if (grant_d) begin
            dbuf_v <= 1'b0;
         end else if (d_acc) begin
            dbuf_v     <= 1'b1;
            dbuf_addr  <= dmem_addr;
            dbuf_rmask <= (|dmem_wmask) ? 4'h0 : dmem_rmask;
            dbuf_wmask <= dmem_wmask;
            dbuf_wdata <= dmem_wdata;
         end

         // Drop flag: the in-flight fetch was flushed; swallow its response.
         if (done && (state == BUSY_I)) begin
            drop <= 1'b0;
         end else if (imem_flush && i_busy) begin
            drop <= 1'b1;
         end

         if (grant_d) begin
            state     <= BUSY_D;
            last_d    <= 1'b1;
            mem_addr  <= d_addr;
            mem_rmask <= d_rm;
            mem_wmask <= d_wm;
            mem_wdata <= d_wdata;
         end else if (grant_i) begin
            state     <= BUSY_I;
            last_d    <= 1'b0;
            mem_addr  <= i_addr;
            mem_rmask <= i_rm;
            mem_wmask <= 4'h0;
            mem_wdata <= 32'h0;
         end else if (done) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a memory model, with queue-based response scoreboard.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic        imem_flush;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        busy;
   logic        proto_err;

   logic [31:0] imem_rdata_f;
   logic        imem_resp_f;
   logic [31:0] dmem_rdata_f;
   logic        dmem_resp_f;
   logic [31:0] mem_addr_f;
   logic [3:0]  mem_rmask_f;
   logic [3:0]  mem_wmask_f;
   logic [31:0] mem_wdata_f;
   logic [31:0] mem_rdata_f;
   logic        mem_resp_f;
   logic        busy_f;
   logic        proto_err_f;

   mem_port_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_flush(imem_flush), .imem_rdata(imem_rdata),
      .imem_resp(imem_resp),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .busy(busy), .proto_err(proto_err)
   );

   mem_port_arbiter #(.RR_EN(1'b0)) dut_fix (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_flush(imem_flush), .imem_rdata(imem_rdata_f),
      .imem_resp(imem_resp_f),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata_f), .dmem_resp(dmem_resp_f),
      .mem_addr(mem_addr_f), .mem_rmask(mem_rmask_f),
      .mem_wmask(mem_wmask_f), .mem_wdata(mem_wdata_f),
      .mem_rdata(mem_rdata_f), .mem_resp(mem_resp_f),
      .busy(busy_f), .proto_err(proto_err_f)
   );

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic [3:0]  rm;
      logic [3:0]  wm;
   } iss_t;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit sb_on = 0;

   logic [31:0] iq[$];
   logic [31:0] dq[$];
   iss_t        ilog[$];
   logic [31:0] flog[$];

   logic [31:0] phys[logic [31:0]];
   logic [31:0] model[logic [31:0]];

   int i_resp_n = 0;
   int d_resp_n = 0;
   int i_resp_cyc = 0;
   int d_resp_cyc = 0;
   int f_i_resp_n = 0;
   bit i_out = 0;
   bit d_out = 0;

   bit          lat_rand = 0;
   int          lat = 1;
   bit          r_pend = 0;
   int          r_cnt = 0;
   logic [31:0] r_data = 0;
   bit          f_pend = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5a5a_a5a5;
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : dflt(a);
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return model.exists(a) ? model[a] : dflt(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic miss(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got response want none (cyc %0d)", nm, cyc);
   endtask

   // Shared-port memory: single outstanding access, byte-masked writes,
   // writes answer with ~addr, idle rdata is garbage.
   always @(negedge clk) begin
      if ((mem_rmask | mem_wmask) != 4'h0) begin
         ilog.push_back('{cyc, mem_addr, mem_rmask, mem_wmask});
         chk("one_outstanding", {31'h0, r_pend}, 32'h0);
         if (mem_wmask != 4'h0) begin
            logic [31:0] v;
            chk("rmask_on_write", {28'h0, mem_rmask}, 32'h0);
            v = phys_rd(mem_addr);
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
            phys[mem_addr] = v;
            r_data = ~mem_addr;
         end else begin
            r_data = phys_rd(mem_addr);
         end
         r_pend = 1;
         r_cnt = lat_rand ? $urandom_range(3, 0) : lat - 1;
      end
   end

   always @(posedge clk) begin
      #1;
      mem_resp  = 0;
      mem_rdata = $urandom;
      if (r_pend) begin
         if (r_cnt == 0) begin
            mem_resp  = 1;
            mem_rdata = r_data;
            r_pend    = 0;
         end else begin
            r_cnt--;
         end
      end
   end

   // Fixed-priority instance: one-cycle latency responder.
   always @(negedge clk) begin
      if ((mem_rmask_f | mem_wmask_f) != 4'h0) begin
         flog.push_back(mem_addr_f);
         f_pend = 1;
      end
      if (imem_resp_f === 1'b1) f_i_resp_n++;
   end

   always @(posedge clk) begin
      #1;
      mem_resp_f  = f_pend;
      mem_rdata_f = 32'h0;
      f_pend      = 0;
   end

   // Response monitor / scoreboard.
   always @(negedge clk) begin
      if (sb_on) begin
         if (imem_resp === 1'b1) begin
            i_resp_n++;
            i_resp_cyc = cyc;
            i_out = 0;
            if (iq.size() == 0) miss("imem_resp_unexp");
            else chk("imem_rdata", imem_rdata, iq.pop_front());
         end else begin
            chk("imem_rdata_idle", imem_rdata, 32'h0);
         end
         if (dmem_resp === 1'b1) begin
            d_resp_n++;
            d_resp_cyc = cyc;
            d_out = 0;
            if (dq.size() == 0) miss("dmem_resp_unexp");
            else chk("dmem_rdata", dmem_rdata, dq.pop_front());
         end else begin
            chk("dmem_rdata_idle", dmem_rdata, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      imem_rmask = 4'h0;
      imem_flush = 1'b0;
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1;
      iq.delete();
      dq.delete();
      i_out = 0;
      d_out = 0;
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_dresp", {31'h0, dmem_resp}, 32'h0);
      tick();
      rst = 0;
      repeat (6) tick();
      ilog.delete();
      flog.delete();
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
      imem_rmask = 4'hf;
      imem_addr  = a;
      iq.push_back(exp);
   endtask

   task automatic dload(input logic [31:0] a);
      dmem_rmask = 4'hf;
      dmem_addr  = a;
      dq.push_back(model_rd(a));
   endtask

   initial begin
      int a;
      int n0;
      int ok;
      rst = 1;
      imem_addr = 0; imem_rmask = 0; imem_flush = 0;
      dmem_addr = 0; dmem_rmask = 0; dmem_wmask = 0; dmem_wdata = 0;
      mem_resp_f = 0; mem_rdata_f = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      sb_on = 1;
      @(negedge clk);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_perr", {31'h0, proto_err}, 32'h0);
      chk("reset_mask", {24'h0, mem_rmask, mem_wmask}, 32'h0);
      chk("reset_addr", mem_addr, 32'h0);
      chk("reset_wdata", mem_wdata, 32'h0);

      // Single fetch, latency 2.
      lat = 2;
      ilog.delete();
      n0 = i_resp_n;
      phys[32'h6000_0000] = 32'h0000_0013;
      tick();
      a = cyc;
      fetch(32'h6000_0000, 32'h0000_0013);
      repeat (6) tick();
      chk("f1_issues", ilog.size(), 1);
      if (ilog.size() >= 1) begin
         chk("f1_iss_cyc", ilog[0].cyc, a + 1);
         chk("f1_iss_addr", ilog[0].addr, 32'h6000_0000);
         chk("f1_iss_rm", {28'h0, ilog[0].rm}, 32'hf);
      end
      chk("f1_resp_n", i_resp_n - n0, 1);
      chk("f1_resp_cyc", i_resp_cyc, a + 3);
      chk("f1_addr_hold", mem_addr, 32'h6000_0000);

      // Round-robin contention from reset: dmem first both times.
      do_reset();
      lat = 1;
      for (int p = 0; p < 2; p++) begin
         tick();
         a = cyc;
         fetch(32'h6000_0010 + p * 4, dflt(32'h6000_0010 + p * 4));
         dload(32'h1000 + p * 4);
         repeat (6) tick();
         chk("rr_issues", ilog.size(), 2);
         if (ilog.size() == 2) begin
            chk("rr_first_d", ilog[0].addr, 32'h1000 + p * 4);
            chk("rr_first_cyc", ilog[0].cyc, a + 1);
            chk("rr_then_i", ilog[1].addr, 32'h6000_0010 + p * 4);
            chk("rr_i_after_d", ilog[1].cyc, d_resp_cyc + 1);
         end
         ilog.delete();
      end

      // Fixed priority: dmem re-requested in each of its response cycles.
      sb_on = 0;
      lat = 1;
      flog.delete();
      n0 = f_i_resp_n;
      tick();
      imem_rmask = 4'hf; imem_addr = 32'h6000_0020;
      dmem_rmask = 4'hf; dmem_addr = 32'h1000;
      for (int j = 0; j < 3; j++) begin
         tick();
         tick();
         dmem_rmask = 4'hf;
         dmem_addr  = 32'h1004 + j * 4;
      end
      repeat (8) tick();
      chk("fix_issues", flog.size(), 5);
      if (flog.size() == 5) begin
         for (int j = 0; j < 4; j++)
            chk("fix_d_order", flog[j], 32'h1000 + j * 4);
         chk("fix_i_last", flog[4], 32'h6000_0020);
      end
      chk("fix_i_resp", f_i_resp_n - n0, 1);
      chk("fix_perr", {31'h0, proto_err_f}, 32'h0);
      do_reset();
      sb_on = 1;

      // Flush of an in-flight fetch, then a normal fetch.
      lat = 3;
      n0 = i_resp_n;
      tick();
      a = cyc;
      fetch(32'h6000_0040, dflt(32'h6000_0040));
      tick();
      tick();
      imem_flush = 1;
      void'(iq.pop_front());
      repeat (3) tick();
      @(negedge clk);
      chk("flush_no_resp", i_resp_n - n0, 0);
      fetch(32'h6000_0044, dflt(32'h6000_0044));
      repeat (6) tick();
      chk("flush_new_resp", i_resp_n - n0, 1);
      chk("flush_new_cyc", i_resp_cyc, a + 9);
      chk("flush_busy", {31'h0, busy}, 32'h0);
      chk("flush_perr", {31'h0, proto_err}, 32'h0);

      // Second dmem request while in flight.
      lat = 4;
      ilog.delete();
      n0 = d_resp_n;
      tick();
      a = cyc;
      dload(32'h1010);
      tick();
      tick();
      dmem_rmask = 4'hf; dmem_addr = 32'h1014;
      tick();
      @(negedge clk);
      chk("perr_set", {31'h0, proto_err}, 32'h1);
      repeat (6) tick();
      chk("perr_issues", ilog.size(), 1);
      chk("perr_resp_n", d_resp_n - n0, 1);
      chk("perr_resp_cyc", d_resp_cyc, a + 5);
      chk("perr_sticky", {31'h0, proto_err}, 32'h1);
      do_reset();
      chk("perr_cleared", {31'h0, proto_err}, 32'h0);

      // Reset while BUSY_D; stale mem_resp must be ignored.
      lat = 4;
      n0 = d_resp_n;
      tick();
      dmem_wmask = 4'hf; dmem_addr = 32'h3000; dmem_wdata = 32'hcafe_f00d;
      dq.push_back(~32'h3000);
      tick();
      tick();
      rst = 1;
      dq.delete();
      @(negedge clk);
      chk("rstd_busy0", {31'h0, busy}, 32'h0);
      chk("rstd_resp0", {31'h0, dmem_resp}, 32'h0);
      tick();
      rst = 0;
      ok = 1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (busy !== 1'b0 || mem_rmask !== 4'h0 || mem_wmask !== 4'h0)
            ok = 0;
         tick();
      end
      chk("rstd_quiet", ok, 1);
      chk("rstd_no_resp", d_resp_n - n0, 0);
      chk("rstd_issues", ilog.size(), 1);
      do_reset();

      // Randomized traffic.
      lat_rand = 1;
      begin
         int hold;
         hold = 0;
         for (int c = 0; c < 3000; c++) begin
            tick();
            if (hold > 0) begin
               hold--;
            end else if (!i_out && $urandom_range(2, 0) == 0) begin
               logic [31:0] ia;
               ia = 32'h6000_0100 + $urandom_range(63, 0) * 4;
               fetch(ia, model_rd(ia));
               i_out = 1;
            end else if (i_out && $urandom_range(19, 0) == 0) begin
               imem_flush = 1;
               if (iq.size() > 0) void'(iq.pop_front());
               i_out = 0;
               hold = 8;
            end
            if (!d_out && $urandom_range(2, 0) == 0) begin
               logic [31:0] da;
               logic [31:0] v;
               int k;
               da = 32'h1000 + $urandom_range(15, 0) * 4;
               k = $urandom_range(2, 0);
               dmem_addr = da;
               if (k == 0) begin
                  dload(da);
               end else begin
                  dmem_wmask = 4'($urandom_range(15, 1));
                  dmem_wdata = $urandom;
                  if (k == 2) dmem_rmask = 4'hf;
                  v = model_rd(da);
                  for (int b = 0; b < 4; b++)
                     if (dmem_wmask[b]) v[8*b +: 8] = dmem_wdata[8*b +: 8];
                  model[da] = v;
                  dq.push_back(~da);
               end
               d_out = 1;
            end
         end
      end
      ok = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (!i_out && !d_out) begin
            ok = 1;
            break;
         end
      end
      chk("rand_drain", ok, 1);
      repeat (4) tick();
      @(negedge clk);
      chk("rand_iq_empty", iq.size(), 0);
      chk("rand_dq_empty", dq.size(), 0);
      chk("rand_perr", {31'h0, proto_err}, 32'h0);
      chk("rand_busy", {31'h0, busy}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
